multiplier_datapath: RTL
========================

// Module: multiplier_datapath
// PURPOSE
//   Register datapath of the sequential shift-add multiplier; sits directly downstream of the Controller FSM.
//   Executes the FSM's Load_Regs / Add_Regs / Shift_Regs / Decr_P commands on registers M, A, C, Q and P.
//   Returns the Q0 and Zero status bits that steer the FSM, and exposes the 2*WIDTH-bit product.
// PARAMETERS
//   WIDTH  8                      operand width in bits (>=2)
//   CNT_W  $clog2(WIDTH+1)        bit-counter width (derived; do not override)
// PORTS
//   Clock         in   1        rising-edge clock
//   Reset         in   1        synchronous, active-high reset
//   Multiplicand  in   WIDTH    operand captured into M on Load_Regs
//   Multiplier    in   WIDTH    operand captured into Q on Load_Regs
//   Load_Regs     in   1        FSM command: initialise all registers
//   Add_Regs      in   1        FSM command: {C,A} <= A + M
//   Shift_Regs    in   1        FSM command: shift {C,A,Q} right by one
//   Decr_P        in   1        FSM command: decrement bit counter P
//   Q0            out  1        Q[0]; tells FSM whether to add
//   Zero          out  1        1 when P == 0; tells FSM to finish
//   Product       out  2*WIDTH  {A,Q}; valid once Zero=1 after a full run
//   Ctrl_Error    out  1        registered 1-cycle pulse on an illegal command mix
// BEHAVIOUR
//   - All state registered on rising Clock edge; command effects visible the cycle after assertion.
//   - Reset (sync, overrides every command): M=0, A=0, C=0, Q=0, P=0, Ctrl_Error=0.
//     Outputs after reset: Q0=0, Zero=1, Product=0.
//   - Q0=Q[0], Zero=(P==0), Product={A,Q}: combinational decodes of registers, no extra latency.
//   - Load_Regs (highest priority): M<=Multiplicand, Q<=Multiplier, A<=0, C<=0, P<=WIDTH.
//   - Load_Regs with any other command: load wins, others ignored, Ctrl_Error=1 next cycle.
//   - Add_Regs alone: {C,A} <= {1'b0,A} + {1'b0,M} (WIDTH+1-bit sum, carry kept in C); Q, P unchanged.
//   - Shift_Regs alone: {C,A,Q} <= {1'b0,C,A,Q[WIDTH-1:1]}; i.e. C->A[MSB], A[0]->Q[MSB], Q[0] dropped, C<=0.
//   - Add_Regs+Shift_Regs together (legal, one cycle per bit): shift applied to the sum.
//     Result {C,A,Q} <= {1'b0, A+M (WIDTH+1 bits), Q[WIDTH-1:1]}.
//   - Decr_P: P<=P-1; legal alongside Add/Shift.
//   - Decr_P at P==0: P holds at 0 (saturate, no wrap); Ctrl_Error=1 next cycle.
//   - No command asserted: all registers hold.
//   - Ctrl_Error otherwise 0; it never alters datapath state beyond the rules above.
//   - Reset asserted mid-multiply: next cycle all registers cleared as above. A following Load_Regs restarts cleanly.
//   - After Load then WIDTH iterations of (Add if Q0) + Shift + Decr: Product = Multiplicand*Multiplier (unsigned) and Zero=1.
// TESTING
//   - Reset, then idle 3 cycles -> Q0=0, Zero=1, Product=0, Ctrl_Error=0.
//   - WIDTH=8, load 0x05*0x03, run 8 bit-iterations (Add on Q0=1, Shift+Decr each) -> Product=0x000F, Zero=1 after 8th Decr.
//   - Load 0xFF*0xFF, combined Add+Shift+Decr when Q0=1 -> carry through C every step; Product=0xFE01.
//   - Load 0x7B*0x00 -> Q0 stays 0, no adds; after 8 Shift+Decr: Product=0x0000, Zero=1.
//   - Load Multiplier=0x01 while P==0, Decr_P at P==0 -> P stays 0, Zero=1, Ctrl_Error pulses exactly 1 cycle.
//   - Load_Regs+Shift_Regs same cycle -> registers equal pure load (A=0, Q=Multiplier, P=8); Ctrl_Error=1.
//   - Reset at iteration 4 -> all cleared next cycle.
//   - Reload 0x0A*0x0C and run 8 iterations -> Product=0x0078.

Source files
------------

// File: rtl/multiplier_datapath.sv
// Register datapath of the sequential shift-add multiplier (M, A, C, Q, P).
// Executes load/add/shift/decrement commands and reports Q0, Zero, Product and command errors.
module multiplier_datapath #(
   parameter int WIDTH = 8,
   parameter int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic                 Clock,
   input  logic                 Reset,
   input  logic [WIDTH-1:0]     Multiplicand,
   input  logic [WIDTH-1:0]     Multiplier,
   input  logic                 Load_Regs,
   input  logic                 Add_Regs,
   input  logic                 Shift_Regs,
   input  logic                 Decr_P,
   output logic                 Q0,
   output logic                 Zero,
   output logic [2*WIDTH-1:0]   Product,
   output logic                 Ctrl_Error
);

   localparam logic [CNT_W-1:0] P_INIT = CNT_W'(WIDTH);

   logic [WIDTH-1:0] r_m;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_q;
   logic             r_c;
   logic [CNT_W-1:0] r_p;
   logic             r_ctrl_error;

   logic [WIDTH:0]   w_sum;
   logic             w_p_zero;
   logic             w_illegal;

   assign w_sum    = {1'b0, r_a} + {1'b0, r_m};
   assign w_p_zero = (r_p == '0);

   // Load mixed with anything else, or a decrement that would underflow P.
   assign w_illegal = (Load_Regs && (Add_Regs || Shift_Regs || Decr_P)) ||
                      (!Load_Regs && Decr_P && w_p_zero);

   always_ff @(posedge Clock) begin
      if (Reset) begin
         r_m          <= '0;
         r_a          <= '0;
         r_q          <= '0;
         r_c          <= 1'b0;
         r_p          <= '0;
         r_ctrl_error <= 1'b0;
      end else begin
         r_ctrl_error <= w_illegal;
         if (Load_Regs) begin
            r_m <= Multiplicand;
            r_q <= Multiplier;
            r_a <= '0;
            r_c <= 1'b0;
            r_p <= P_INIT;
         end else begin
            // Combined add+shift retires one multiplier bit per cycle.
            if (Add_Regs && Shift_Regs) begin
               r_c <= 1'b0;
               r_a <= w_sum[WIDTH:1];
               r_q <= {w_sum[0], r_q[WIDTH-1:1]};
            end else if (Add_Regs) begin
               r_c <= w_sum[WIDTH];
               r_a <= w_sum[WIDTH-1:0];
            end else if (Shift_Regs) begin
               r_c <= 1'b0;
               r_a <= {r_c, r_a[WIDTH-1:1]};
               r_q <= {r_a[0], r_q[WIDTH-1:1]};
            end
            if (Decr_P && !w_p_zero) begin
               r_p <= r_p - 1'b1;
            end
         end
      end
   end

   assign Q0         = r_q[0];
   assign Zero       = w_p_zero;
   assign Product    = {r_a, r_q};
   assign Ctrl_Error = r_ctrl_error;

endmodule
